conv_state_top: RTL and testbench
=================================

# conv_state_top

Top-level layer sequencer for the convolution unit. It drives the 3-bit `current_state` bus that the convolution controller decodes into scale and adder/buffer control, and it consumes that controller's `state_rst` return. Per layer it walks INIT → A (row-buffer prefill) → B (steady convolution) → C (pipeline drain) once per input-channel pass. It also gates the input pixel stream and tracks column, row and pass position.

## Interface
- `KERNEL_SIZE`, 3: kernel height; rows buffered before outputs are valid.
- `DIM_WIDTH`, 9: width of image width/height fields and of the col/row counters.
- `PASS_WIDTH`, 4: width of the pass count and pass counter.
- `DRAIN_CYCLES`, 4: cycles spent in C; equals multiplier pipeline (2) plus adder tree (2).

- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle layer start; sampled only in INIT.
- `img_width`  in  DIM_WIDTH  pixels per row; latched on accepted start.
- `img_height`  in  DIM_WIDTH  rows per image; latched on accepted start.
- `pass_num`  in  PASS_WIDTH  number of input-channel passes; latched on accepted start.
- `pixel_valid`  in  1  upstream pixel present.
- `in_ready`  out  1  high in A and B; pixel accepted when `pixel_valid && in_ready`.
- `state_rst`  in  1  abort request from the convolution controller.
- `current_state`  out  3  000 INIT, 001 A, 010 B, 011 C.
- `col_cnt`  out  DIM_WIDTH  column of the next pixel to be accepted.
- `row_cnt`  out  DIM_WIDTH  row of the next pixel to be accepted.
- `pass_cnt`  out  PASS_WIDTH  current pass index.
- `busy`  out  1  `current_state != INIT`.
- `done`  out  1  one-cycle pulse at layer completion.
- `cfg_err`  out  1  one-cycle pulse on rejected start.

## Operation
- Reset values: `current_state`=INIT; `col_cnt`, `row_cnt`, `pass_cnt` = 0; `done`=0; `cfg_err`=0; latched config = 0.
- INIT: on `start`, validate the config. Start is rejected if `img_width==0`, `img_height<KERNEL_SIZE` or `pass_num==0`. A rejected start pulses `cfg_err` next cycle and the block stays in INIT. A valid start latches the config and moves to A.
- Column/row counting on each accepted pixel:
  - `col_cnt` increments.
  - At `img_width-1`, `col_cnt` wraps to 0 and `row_cnt` increments.
- A → B on the accepted pixel at col `img_width-1`, row `KERNEL_SIZE-2`.
- B → C on the accepted pixel at col `img_width-1`, row `img_height-1`. `col_cnt` and `row_cnt` clear to 0.
- C: a drain counter runs for exactly `DRAIN_CYCLES` cycles; no pixels are accepted. Then:
  - if `pass_cnt < pass_num-1`: increment `pass_cnt` and go to A.
  - else: clear `pass_cnt`, go to INIT, and pulse `done`.
- `state_rst` high in any state: next cycle goes to INIT and clears all counters. No `done` pulse.
- Priority: `rst` > `state_rst` > normal transitions.
- `start` outside INIT is ignored. `pixel_valid` in INIT or C is ignored.
- Counters are unsigned. Comparisons use the latched config; live inputs are never used after start.

## Timing
- All outputs are registered except `in_ready` and `busy`, which decode `current_state` combinationally.
- `start` at cycle t → `current_state`=A at t+1.
- A state change caused by an accepted pixel at cycle t is visible at t+1.
- A pass with continuous `pixel_valid` lasts `img_width*img_height + DRAIN_CYCLES` cycles.
- `done` is high in the first INIT cycle after the final C.
- `cfg_err` is high at t+1 after a rejected start at t.

## Configuration
- `CONV_STATE_PERF_CNT_EN` defined:
  - adds output `cycle_cnt` (32 bits), counting cycles while `busy`.
  - adds output `stall_cnt` (32 bits), counting cycles in A/B with `pixel_valid` low.
  - both clear on accepted start and on `rst`; they hold after `done`.
- Undefined: neither port exists and no counter logic is built.

## Structure
- Shared package `conv_pkg`:
  - state encodings `INIT_STATE`, `A_STATE`, `B_STATE`, `C_STATE`, 3 bits each;
  - default `DRAIN_CYCLES`.
- The convolution controller imports the same constants.
- One sub-module, `conv_pos_counter`: col/row counter with width wrap, terminal-flag outputs and synchronous clear.

## Test plan
- Width 4, height 4, K=3, drain 4, `pass_num`=2, continuous valid, start at t:
  - A at t+1..t+8, B at t+9..t+16, C at t+17..t+20;
  - pass 2 repeats at t+21..t+40;
  - INIT and `done`=1 at t+41.
- Same config with `pixel_valid` low every other cycle → A lasts 16 cycles and `row_cnt`/`col_cnt` advance only on accepts.
- `img_height`=2, K=3 → `cfg_err` pulse at t+1, `current_state` stays 000, `busy`=0.
- `state_rst` asserted mid-B at row 2, col 1 → next cycle INIT with all counters 0, no `done`; a new start then runs normally.
- `start` pulsed during B with a different `img_width` → ignored; the layer completes using the original width.
- With `CONV_STATE_PERF_CNT_EN`, first scenario with 3 idle cycles inserted in B → `stall_cnt`=3, `cycle_cnt`=43.

Source files
------------

// File: rtl/conv_pkg.sv
// Constants shared by the layer sequencer and the convolution controller:
// the 3-bit state encodings and the default kernel and drain depths.
package conv_pkg;

   typedef enum logic [2:0] {
      INIT_STATE = 3'b000,
      A_STATE    = 3'b001,
      B_STATE    = 3'b010,
      C_STATE    = 3'b011
   } conv_state_e;

   localparam int DEFAULT_KERNEL_SIZE  = 3;
   // The multiplier pipeline takes 2 cycles and the adder tree takes 2 more.
   localparam int DEFAULT_DRAIN_CYCLES = 4;

endpackage

// File: rtl/conv_pos_counter.sv
// Column/row position counter. The column wraps at the image width and
// carries into the row. Terminal flags mark the last column and the last row.
module conv_pos_counter
   import conv_pkg::*;
#(
   parameter int DIM_WIDTH = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 inc,
   input  logic [DIM_WIDTH-1:0] width,
   input  logic [DIM_WIDTH-1:0] height,
   output logic [DIM_WIDTH-1:0] col,
   output logic [DIM_WIDTH-1:0] row,
   output logic                 col_last,
   output logic                 row_last
);

   assign col_last = (col == width - DIM_WIDTH'(1));
   assign row_last = (row == height - DIM_WIDTH'(1));

   // clr takes priority over inc, so the last pixel of a frame lands on 0/0.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         col <= '0;
         row <= '0;
      end else if (inc) begin
         if (col_last) begin
            col <= '0;
            row <= row + DIM_WIDTH'(1);
         end else begin
            col <= col + DIM_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/conv_state_top.sv
// Layer sequencer for the convolution unit: INIT -> A -> B -> C once per pass.
// Optional cycle/stall counters are built when CONV_STATE_PERF_CNT_EN is defined.
//
// state | meaning
// INIT  | idle, waiting for a valid start
// A     | row-buffer prefill (rows 0 .. KERNEL_SIZE-2)
// B     | steady convolution (remaining rows)
// C     | pipeline drain, DRAIN_CYCLES cycles, no pixels accepted
module conv_state_top
   import conv_pkg::*;
#(
   parameter int KERNEL_SIZE  = DEFAULT_KERNEL_SIZE,
   parameter int DIM_WIDTH    = 9,
   parameter int PASS_WIDTH   = 4,
   parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DIM_WIDTH-1:0]  img_width,
   input  logic [DIM_WIDTH-1:0]  img_height,
   input  logic [PASS_WIDTH-1:0] pass_num,
   input  logic                  pixel_valid,
   output logic                  in_ready,
   input  logic                  state_rst,
   output logic [2:0]            current_state,
   output logic [DIM_WIDTH-1:0]  col_cnt,
   output logic [DIM_WIDTH-1:0]  row_cnt,
   output logic [PASS_WIDTH-1:0] pass_cnt,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_err
`ifdef CONV_STATE_PERF_CNT_EN
   ,
   output logic [31:0]           cycle_cnt,
   output logic [31:0]           stall_cnt
`endif
);

   localparam int DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DRAIN_W-1:0]   DRAIN_LOAD       = DRAIN_W'(DRAIN_CYCLES - 1);
   localparam logic [DIM_WIDTH-1:0] ROW_PREFILL_LAST = DIM_WIDTH'(KERNEL_SIZE - 2);
   localparam logic [DIM_WIDTH-1:0] KERNEL_ROWS      = DIM_WIDTH'(KERNEL_SIZE);

   conv_state_e           state_q;
   logic [DIM_WIDTH-1:0]  cfg_width;
   logic [DIM_WIDTH-1:0]  cfg_height;
   logic [PASS_WIDTH-1:0] cfg_pass;
   logic [DRAIN_W-1:0]    drain_cnt;
   logic                  accept;
   logic                  col_last;
   logic                  row_last;
   logic                  frame_end;
   logic                  cfg_ok;
   logic                  start_ok;

   assign in_ready      = (state_q == A_STATE) || (state_q == B_STATE);
   assign busy          = (state_q != INIT_STATE);
   assign current_state = state_q;
   assign accept        = pixel_valid && in_ready;
   assign frame_end     = accept && (state_q == B_STATE) && col_last && row_last;
   assign cfg_ok        = (img_width != '0) && (img_height >= KERNEL_ROWS) && (pass_num != '0);
   assign start_ok      = (state_q == INIT_STATE) && start && cfg_ok && !state_rst;

   conv_pos_counter #(
      .DIM_WIDTH (DIM_WIDTH)
   ) u_pos (
      .clk      (clk),
      .rst      (rst),
      .clr      (state_rst || frame_end),
      .inc      (accept),
      .width    (cfg_width),
      .height   (cfg_height),
      .col      (col_cnt),
      .row      (row_cnt),
      .col_last (col_last),
      .row_last (row_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= INIT_STATE;
         cfg_width  <= '0;
         cfg_height <= '0;
         cfg_pass   <= '0;
         pass_cnt   <= '0;
         drain_cnt  <= '0;
         done       <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         if (state_rst) begin
            state_q   <= INIT_STATE;
            pass_cnt  <= '0;
            drain_cnt <= '0;
         end else begin
            case (state_q)
               INIT_STATE: begin
                  if (start) begin
                     if (cfg_ok) begin
                        cfg_width  <= img_width;
                        cfg_height <= img_height;
                        cfg_pass   <= pass_num;
                        pass_cnt   <= '0;
                        state_q    <= A_STATE;
                     end else begin
                        cfg_err <= 1'b1;
                     end
                  end
               end
               A_STATE: begin
                  if (accept && col_last && (row_cnt == ROW_PREFILL_LAST))
                     state_q <= B_STATE;
               end
               B_STATE: begin
                  if (frame_end) begin
                     drain_cnt <= DRAIN_LOAD;
                     state_q   <= C_STATE;
                  end
               end
               C_STATE: begin
                  if (drain_cnt == '0) begin
                     // cfg_pass is never 0 once latched, so the subtract cannot wrap.
                     if (pass_cnt < cfg_pass - PASS_WIDTH'(1)) begin
                        pass_cnt <= pass_cnt + PASS_WIDTH'(1);
                        state_q  <= A_STATE;
                     end else begin
                        pass_cnt <= '0;
                        done     <= 1'b1;
                        state_q  <= INIT_STATE;
                     end
                  end else begin
                     drain_cnt <= drain_cnt - DRAIN_W'(1);
                  end
               end
               default: state_q <= INIT_STATE;
            endcase
         end
      end
   end

`ifdef CONV_STATE_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         cycle_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (busy)
            cycle_cnt <= cycle_cnt + 32'd1;
         if (in_ready && !pixel_valid)
            stall_cnt <= stall_cnt + 32'd1;
      end
   end
`else
   logic unused_start_ok;
   assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_conv_state_top.sv
// Self-checking bench for conv_state_top: config table, test-plan sequences
// and a randomized run against a pixel-count based reference model.
module tb_conv_state_top;
   import conv_pkg::*;

   localparam int K = 3;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst, start, pixel_valid, state_rst;
   logic [8:0] img_width, img_height;
   logic [3:0] pass_num;
   logic       in_ready, busy, done, cfg_err;
   logic [2:0] current_state;
   logic [8:0] col_cnt, row_cnt;
   logic [3:0] pass_cnt;
`ifdef CONV_STATE_PERF_CNT_EN
   logic [31:0] cycle_cnt, stall_cnt;
`endif

   conv_state_top #(
      .KERNEL_SIZE  (K),
      .DIM_WIDTH    (9),
      .PASS_WIDTH   (4),
      .DRAIN_CYCLES (D)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .img_width     (img_width),
      .img_height    (img_height),
      .pass_num      (pass_num),
      .pixel_valid   (pixel_valid),
      .in_ready      (in_ready),
      .state_rst     (state_rst),
      .current_state (current_state),
      .col_cnt       (col_cnt),
      .row_cnt       (row_cnt),
      .pass_cnt      (pass_cnt),
      .busy          (busy),
      .done          (done),
      .cfg_err       (cfg_err)
`ifdef CONV_STATE_PERF_CNT_EN
      ,
      .cycle_cnt     (cycle_cnt),
      .stall_cnt     (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: position is the number of pixels accepted in this pass.
   bit m_active;
   int m_w, m_h, m_p, m_n, m_pass, m_drain;
   bit m_done, m_cfg_err;
   int m_cyc, m_stall;

   function automatic int m_state();
      if (!m_active)              return 0;
      if (m_n < m_w * (K - 1))    return 1;
      if (m_n < m_w * m_h)        return 2;
      return 3;
   endfunction

   function automatic bit cfg_valid();
      return (img_width != 0) && (img_height >= K) && (pass_num != 0);
   endfunction

   task automatic model_step(input bit s, input bit pv, input bit sr);
      int st;
      st = m_state();
      if (!m_active && s && cfg_valid() && !sr) begin
         m_cyc   = 0;
         m_stall = 0;
      end else begin
         if (st != 0) m_cyc++;
         if ((st == 1 || st == 2) && !pv) m_stall++;
      end
      m_done    = 0;
      m_cfg_err = 0;
      if (sr) begin
         m_active = 0; m_n = 0; m_pass = 0; m_drain = 0;
      end else if (!m_active) begin
         if (s) begin
            if (cfg_valid()) begin
               m_w = int'(img_width); m_h = int'(img_height); m_p = int'(pass_num);
               m_active = 1; m_n = 0; m_pass = 0; m_drain = 0;
            end else begin
               m_cfg_err = 1;
            end
         end
      end else if (st == 3) begin
         m_drain++;
         if (m_drain == D) begin
            m_drain = 0;
            m_n     = 0;
            if (m_pass < m_p - 1) m_pass++;
            else begin
               m_pass = 0; m_active = 0; m_done = 1;
            end
         end
      end else if (pv) begin
         m_n++;
      end
   endtask

   task automatic compare_all();
      int st, ec, er;
      st = m_state();
      ec = 0; er = 0;
      if (st == 1 || st == 2) begin
         ec = m_n % m_w;
         er = m_n / m_w;
      end
      check("state",    32'(current_state), st);
      check("col_cnt",  32'(col_cnt), ec);
      check("row_cnt",  32'(row_cnt), er);
      check("pass_cnt", 32'(pass_cnt), m_pass);
      check("busy",     32'(busy), 32'(st != 0));
      check("in_ready", 32'(in_ready), 32'(st == 1 || st == 2));
      check("done",     32'(done), 32'(m_done));
      check("cfg_err",  32'(cfg_err), 32'(m_cfg_err));
`ifdef CONV_STATE_PERF_CNT_EN
      check("cycle_cnt", cycle_cnt, m_cyc);
      check("stall_cnt", stall_cnt, m_stall);
`endif
   endtask

   task automatic cyc(input bit s, input bit pv, input bit sr);
      start = s; pixel_valid = pv; state_rst = sr;
      model_step(s, pv, sr);
      @(posedge clk);
      #1;
      compare_all();
      start = 1'b0; state_rst = 1'b0;
   endtask

   task automatic set_cfg(input int w, input int h, input int p);
      img_width = 9'(w); img_height = 9'(h); pass_num = 4'(p);
   endtask

   // Runs with the given valid pattern until the model reports layer completion.
   task automatic run_to_done(input bit always_valid, output int cycles);
      cycles = 0;
      while (!m_done) begin
         if (cycles >= 5000) begin
            check("run_to_done_timeout", 1, 0);
            break;
         end
         cyc(1'b0, always_valid ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0);
         cycles++;
      end
   endtask

   function automatic int plan_state(input int k);
      if (k <= 8)  return 1;
      if (k <= 16) return 2;
      if (k <= 20) return 3;
      if (k <= 28) return 1;
      if (k <= 36) return 2;
      if (k <= 40) return 3;
      return 0;
   endfunction

   typedef struct {
      int w;
      int h;
      int p;
      bit exp_err;
      int exp_state;
   } cfg_vec_t;

   cfg_vec_t vecs[8];

   initial begin
      int cyc_n, a_cnt, guard, idle_left;

      vecs[0] = '{4,   4,   2,  1'b0, 1};
      vecs[1] = '{4,   2,   2,  1'b1, 0};
      vecs[2] = '{0,   4,   1,  1'b1, 0};
      vecs[3] = '{4,   4,   0,  1'b1, 0};
      vecs[4] = '{1,   3,   1,  1'b0, 1};
      vecs[5] = '{5,   3,   1,  1'b0, 1};
      vecs[6] = '{3,   0,   1,  1'b1, 0};
      vecs[7] = '{511, 511, 15, 1'b0, 1};

      rst = 1'b1; start = 1'b0; pixel_valid = 1'b0; state_rst = 1'b0;
      set_cfg(0, 0, 0);
      m_active = 0; m_w = 0; m_h = 0; m_p = 0; m_n = 0; m_pass = 0; m_drain = 0;
      m_done = 0; m_cfg_err = 0; m_cyc = 0; m_stall = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state",   32'(current_state), 0);
      check("reset_col",     32'(col_cnt), 0);
      check("reset_row",     32'(row_cnt), 0);
      check("reset_pass",    32'(pass_cnt), 0);
      check("reset_done",    32'(done), 0);
      check("reset_cfg_err", 32'(cfg_err), 0);
      check("reset_busy",    32'(busy), 0);
      rst = 1'b0;
      cyc(1'b0, 1'b1, 1'b0);

      // Start validation table
      foreach (vecs[i]) begin
         set_cfg(vecs[i].w, vecs[i].h, vecs[i].p);
         cyc(1'b1, 1'b0, 1'b0);
         check("tbl_cfg_err", 32'(cfg_err), 32'(vecs[i].exp_err));
         check("tbl_state",   32'(current_state), vecs[i].exp_state);
         check("tbl_busy",    32'(busy), 32'(vecs[i].exp_state != 0));
         cyc(1'b0, 1'b0, 1'b1);
         check("tbl_rst_state", 32'(current_state), 0);
      end

      // Test-plan timeline: 4x4, two passes, continuous valid
      set_cfg(4, 4, 2);
      cyc(1'b1, 1'b1, 1'b0);
      for (int k = 1; k <= 41; k++) begin
         check("timeline_state", 32'(current_state), plan_state(k));
         if (k == 41) check("timeline_done", 32'(done), 1);
         if (k < 41) cyc(1'b0, 1'b1, 1'b0);
      end
      cyc(1'b0, 1'b1, 1'b0);
      check("done_one_cycle", 32'(done), 0);

      // Every other cycle valid: prefill takes 16 cycles
      set_cfg(4, 4, 1);
      cyc(1'b1, 1'b0, 1'b0);
      a_cnt = 0; guard = 0;
      for (int k = 1; !m_done && guard < 500; k++) begin
         if (current_state == 3'd1) a_cnt++;
         cyc(1'b0, (k % 2) == 0, 1'b0);
         guard++;
      end
      check("alt_valid_a_cycles", a_cnt, 16);
      check("alt_valid_finished", 32'(m_done), 1);

      // Abort mid-B at row 2, col 1
      set_cfg(4, 4, 2);
      cyc(1'b1, 1'b1, 1'b0);
      guard = 0;
      while (m_n != 9 && guard < 100) begin
         cyc(1'b0, 1'b1, 1'b0);
         guard++;
      end
      check("abort_pos_row", 32'(row_cnt), 2);
      check("abort_pos_col", 32'(col_cnt), 1);
      cyc(1'b0, 1'b1, 1'b1);
      check("abort_state", 32'(current_state), 0);
      check("abort_row",   32'(row_cnt), 0);
      check("abort_col",   32'(col_cnt), 0);
      check("abort_done",  32'(done), 0);
      cyc(1'b1, 1'b1, 1'b0);
      run_to_done(1'b1, cyc_n);
      check("restart_cycles", cyc_n, 40);

      // Start during B with a different width is ignored
      set_cfg(4, 4, 2);
      cyc(1'b1, 1'b1, 1'b0);
      cyc_n = 1;
      while (m_state() != 2 && cyc_n < 100) begin
         cyc(1'b0, 1'b1, 1'b0);
         cyc_n++;
      end
      set_cfg(2, 4, 2);
      cyc(1'b0 | 1'b1, 1'b1, 1'b0);
      cyc_n++;
      check("ignored_start_state", 32'(current_state), 2);
      run_to_done(1'b1, guard);
      check("ignored_start_total", cyc_n + guard, 41);

`ifdef CONV_STATE_PERF_CNT_EN
      set_cfg(4, 4, 2);
      cyc(1'b1, 1'b1, 1'b0);
      idle_left = 3;
      guard = 0;
      while (!m_done && guard < 200) begin
         if (m_state() == 2 && idle_left > 0) begin
            cyc(1'b0, 1'b0, 1'b0);
            idle_left--;
         end else begin
            cyc(1'b0, 1'b1, 1'b0);
         end
         guard++;
      end
      check("perf_cycle_cnt", cycle_cnt, 43);
      check("perf_stall_cnt", stall_cnt, 3);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      check("perf_cycle_hold", cycle_cnt, 43);
`else
      idle_left = 0;
`endif

      // Randomized run
      for (int i = 0; i < 3000; i++) begin
         bit s, pv, sr;
         s  = 1'b0;
         sr = ($urandom_range(0, 199) == 0);
         pv = ($urandom_range(0, 3) != 0);
         if ((!m_active && $urandom_range(0, 3) == 0) || $urandom_range(0, 49) == 0) begin
            set_cfg($urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 3));
            s = 1'b1;
         end
         cyc(s, pv, sr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
